regfile_scoreboard: RTL and testbench

//  Parametrised register file for the ID stage, with write-through bypass and a per-register

---
 rtl/regfile_scoreboard.sv | 138 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: ID-stage register file with write-through bypass and a
// per-register pending-write counter (scoreboard) that feeds the hazard/stall unit.
// Issue bumps a destination's counter, writeback retires it, flush squashes all.
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int PEND_W   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy1,
    output logic              busy2,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    output logic              sat_err
);

    localparam int              NumRegs = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0] PendMax = '1;
    localparam logic [PEND_W-1:0] PendOne = PEND_W'(1);
    localparam bit              ZeroEn  = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [NumRegs];
    logic [PEND_W-1:0] pend [NumRegs];

    // Qualified requests: register 0 is hardwired when ZeroEn, and a flush
    // squashes the instruction issuing alongside it.
    logic wrOk;
    logic issOk;
    logic issWrSame;
    logic issSat;
    logic byp1;
    logic byp2;

    assign wrOk      = wr_en && !(ZeroEn && (wr_addr == '0));
    assign issOk     = iss_en && !flush && !(ZeroEn && (iss_addr == '0));
    assign issWrSame = issOk && wrOk && (iss_addr == wr_addr);
    // A lone issue onto a full counter cannot be recorded; an issue paired with a
    // retiring write to the same register nets to zero and never saturates.
    assign issSat    = issOk && !issWrSame && (pend[iss_addr] == PendMax);

    // Forwarding is suppressed while in reset so outputs show pure reset values.
    assign byp1 = !rst && wrOk && (wr_addr == rd_addr1);
    assign byp2 = !rst && wrOk && (wr_addr == rd_addr2);

    // Register array: synchronous write from writeback, cleared by async reset.
    // NOTE: the array is built from flops, not RAM, so it can take the async reset;
    // a RAM macro would have to drop the reset and rely on the scoreboard instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NumRegs; r++) begin
                regs[r] <= '0;
            end
        end else if (wrOk) begin
            // NOTE: state is always updated with <= so every flop samples pre-edge values.
            regs[wr_addr] <= wr_data;
        end
    end

    // Pending-write counters: +1 on issue, -1 on writeback, cleared by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NumRegs; r++) begin
                pend[r] <= '0;
            end
        end else if (flush) begin
            for (int r = 0; r < NumRegs; r++) begin
                pend[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NumRegs; r++) begin
                if (issOk && (iss_addr == ADDR_W'(r)) && !issWrSame) begin
                    if (pend[r] != PendMax) begin
                        pend[r] <= pend[r] + PendOne;
                    end
                end else if (wrOk && (wr_addr == ADDR_W'(r)) && !issWrSame) begin
                    // Writes with no counted writer (pre-flush or unscoreboarded) are ignored.
                    if (pend[r] != '0) begin
                        pend[r] <= pend[r] - PendOne;
                    end
                end
            end
        end
    end

    // Sticky saturation error, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_err <= 1'b0;
        end else if (issSat) begin
            sat_err <= 1'b1;
        end
    end

    // Read port 1: hardwired zero, then same-cycle bypass, then array.
    always_comb begin
        // NOTE: default assignment first so no path leaves the output unassigned (no latch).
        rd_data1 = regs[rd_addr1];
        if (ZeroEn && (rd_addr1 == '0)) begin
            rd_data1 = '0;
        end else if (byp1) begin
            rd_data1 = wr_data;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd_data2 = regs[rd_addr2];
        if (ZeroEn && (rd_addr2 == '0)) begin
            rd_data2 = '0;
        end else if (byp2) begin
            rd_data2 = wr_data;
        end
    end

    // Busy flags: outstanding writer, except when the last one retires this
    // cycle and its value is already being forwarded.
    always_comb begin
        busy1 = (pend[rd_addr1] != '0);
        if (busy1 && (pend[rd_addr1] == PendOne) && byp1) begin
            busy1 = 1'b0;
        end
        busy2 = (pend[rd_addr2] != '0);
        if (busy2 && (pend[rd_addr2] == PendOne) && byp2) begin
            busy2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed stimulus with literal expectations, plus a
// behavioural model checked against the DUT on every falling clock edge.
module tb_regfile_scoreboard;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int PW = 2;
    localparam int NR = 16;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk;
    logic          rst;
    logic [AW-1:0] rd_addr1, rd_addr2, iss_addr, wr_addr;
    logic [DW-1:0] rd_data1, rd_data2, wr_data;
    logic          busy1, busy2, iss_en, wr_en, flush, sat_err;

    int nChecks = 0;
    int nFail   = 0;
    bit checkEn = 0;

    // Model state: register contents, number of outstanding writers, sticky error.
    logic [DW-1:0] mRegs [NR];
    int            mPend [NR];
    bit            mSat;

    regfile_scoreboard #(
        .DATA_W(DW), .ADDR_W(AW), .PEND_W(PW), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .busy1(busy1), .busy2(busy2),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .flush(flush), .sat_err(sat_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of a read port: address 0 is hardwired, a live write forwards.
    function automatic logic [DW-1:0] expRd(input int a);
        if (rst || a == 0) return '0;
        if (wr_en && int'(wr_addr) == a) return wr_data;
        return mRegs[a];
    endfunction

    // Model of a busy flag: writers outstanding, minus the one retiring now.
    function automatic bit expBusy(input int a);
        if (rst || a == 0) return 1'b0;
        if (mPend[a] == 0) return 1'b0;
        if (mPend[a] == 1 && wr_en && int'(wr_addr) == a) return 1'b0;
        return 1'b1;
    endfunction

    // Model update at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                mRegs[i] = '0;
                mPend[i] = 0;
            end
            mSat = 1'b0;
        end else begin
            int  wa, ia;
            bit  wOk, iOk;
            wa  = int'(wr_addr);
            ia  = int'(iss_addr);
            wOk = wr_en && wa != 0;
            iOk = iss_en && !flush && ia != 0;
            if (wOk) mRegs[wa] = wr_data;
            if (flush) begin
                for (int i = 0; i < NR; i++) mPend[i] = 0;
            end else if (!(iOk && wOk && ia == wa)) begin
                if (iOk) begin
                    if (mPend[ia] == PMAX) mSat = 1'b1;
                    else mPend[ia] = mPend[ia] + 1;
                end
                if (wOk && mPend[wa] > 0) mPend[wa] = mPend[wa] - 1;
            end
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            check("cmp rd_data1", 32'(rd_data1), 32'(expRd(int'(rd_addr1))));
            check("cmp rd_data2", 32'(rd_data2), 32'(expRd(int'(rd_addr2))));
            check("cmp busy1", 32'(busy1), 32'(expBusy(int'(rd_addr1))));
            check("cmp busy2", 32'(busy2), 32'(expBusy(int'(rd_addr2))));
            check("cmp sat_err", 32'(sat_err), 32'(rst ? 1'b0 : mSat));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        iss_en = 1'b0; iss_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr1 = '0; rd_addr2 = '0;
        checkEn = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // 1. Every register reads zero and idle after reset.
        for (int i = 0; i < NR; i++) begin
            rd_addr1 = AW'(i);
            rd_addr2 = AW'(NR - 1 - i);
            #2;
            check("reset rd_data1", 32'(rd_data1), 32'h0);
            check("reset busy2", 32'(busy2), 32'h0);
            tick();
        end
        check("reset sat_err", 32'(sat_err), 32'h0);

        // 2. Bypass in the write cycle, then plain read.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF; rd_addr1 = 4'd3;
        #2 check("bypass rd_data1", 32'(rd_data1), 32'hBEEF);
        tick();
        wr_en = 1'b0;
        #2 check("plain read r3", 32'(rd_data1), 32'hBEEF);
        tick();

        // 3. Issue then release-bypass on retirement.
        iss_en = 1'b1; iss_addr = 4'd5;
        tick();
        iss_en = 1'b0; rd_addr2 = 4'd5;
        #2 check("busy2 after issue", 32'(busy2), 32'h1);
        tick();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
        #2 check("release busy2", 32'(busy2), 32'h0);
        check("release rd_data2", 32'(rd_data2), 32'h1234);
        tick();
        wr_en = 1'b0;
        #2 check("r5 idle", 32'(busy2), 32'h0);
        tick();

        // 4. Saturate counter on 7, then drain it.
        iss_en = 1'b1; iss_addr = 4'd7; rd_addr1 = 4'd7;
        tick(); tick(); tick();
        iss_en = 1'b0;
        #2 check("busy1 pend3", 32'(busy1), 32'h1);
        check("no sat yet", 32'(sat_err), 32'h0);
        tick();
        iss_en = 1'b1;
        tick();
        iss_en = 1'b0;
        #2 check("sat_err set", 32'(sat_err), 32'h1);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0001;
        tick();
        wr_data = 16'h0002;
        #2 check("busy1 pend2", 32'(busy1), 32'h1);
        tick();
        wr_data = 16'h0003;
        #2 check("busy1 last write", 32'(busy1), 32'h0);
        check("rd_data1 last write", 32'(rd_data1), 32'h0003);
        tick();
        wr_en = 1'b0;
        #2 check("busy1 drained", 32'(busy1), 32'h0);
        check("sat_err sticky", 32'(sat_err), 32'h1);
        tick();

        // Unscoreboarded write at zero must not wrap the counter.
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0077;
        tick();
        wr_en = 1'b0; iss_en = 1'b1; iss_addr = 4'd7;
        tick();
        iss_en = 1'b0;
        #2 check("busy1 after wrap test", 32'(busy1), 32'h1);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0078;
        #2 check("busy1 no wrap", 32'(busy1), 32'h0);
        tick();
        wr_en = 1'b0;

        // Issue and writeback on the same register cancel out.
        iss_en = 1'b1; iss_addr = 4'd8; wr_en = 1'b1; wr_addr = 4'd8; wr_data = 16'h0808;
        rd_addr2 = 4'd8;
        tick();
        iss_en = 1'b0; wr_en = 1'b0;
        #2 check("busy2 iss+wr same reg", 32'(busy2), 32'h0);
        check("rd_data2 r8", 32'(rd_data2), 32'h0808);
        tick();

        // 5. Flush squashes writers; same-cycle write still lands, issue dropped.
        iss_en = 1'b1; iss_addr = 4'd2;
        tick();
        iss_addr = 4'd4;
        tick();
        iss_addr = 4'd9; flush = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h00AA;
        rd_addr1 = 4'd2; rd_addr2 = 4'd4;
        #2 check("busy1 in flush cycle", 32'(busy1), 32'h1);
        tick();
        iss_en = 1'b0; flush = 1'b0; wr_en = 1'b0;
        #2 check("busy1 flushed", 32'(busy1), 32'h0);
        check("busy2 flushed", 32'(busy2), 32'h0);
        tick();
        rd_addr1 = 4'd6; rd_addr2 = 4'd9;
        #2 check("r6 after flush", 32'(rd_data1), 32'h00AA);
        check("flush drops issue", 32'(busy2), 32'h0);
        tick();

        // 6. Register 0 is hardwired.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; rd_addr1 = 4'd0;
        #2 check("r0 no bypass", 32'(rd_data1), 32'h0);
        tick();
        wr_en = 1'b0; iss_en = 1'b1; iss_addr = 4'd0;
        tick();
        iss_en = 1'b0;
        #2 check("r0 reads 0", 32'(rd_data1), 32'h0);
        check("r0 not busy", 32'(busy1), 32'h0);
        tick();

        // Reset mid-burst clears outputs without waiting for a clock edge.
        iss_en = 1'b1; iss_addr = 4'd10; rd_addr1 = 4'd3; rd_addr2 = 4'd10;
        tick();
        iss_en = 1'b0; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hC0DE;
        #2 check("busy2 pre-reset", 32'(busy2), 32'h1);
        rst = 1'b1;
        #1;
        check("async rst rd_data1", 32'(rd_data1), 32'h0);
        check("async rst busy2", 32'(busy2), 32'h0);
        check("async rst sat_err", 32'(sat_err), 32'h0);
        tick();
        rst = 1'b0; wr_data = 16'h5A5A;
        tick();
        wr_en = 1'b0;
        #2 check("first write after reset", 32'(rd_data1), 32'h5A5A);
        tick(); tick();

        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
